// File: rtl/cacheline_adaptor.sv
// Bridges a single-cycle cache-line port to a 4-beat burst memory port.
// Reads assemble the line beat by beat; writes serialise the latched line, beat 0 first.
module cacheline_adaptor #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BEAT_WIDTH  = 64,
    parameter int unsigned OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [31:0]           line_address_i,
    output logic [LINE_WIDTH-1:0] line_rdata_o,
    input  logic [LINE_WIDTH-1:0] line_wdata_i,
    input  logic                  line_read_i,
    input  logic                  line_write_i,
    output logic                  line_resp_o,

    output logic [31:0]           burst_address_o,
    input  logic [BEAT_WIDTH-1:0] burst_rdata_i,
    output logic [BEAT_WIDTH-1:0] burst_wdata_o,
    output logic                  burst_read_o,
    output logic                  burst_write_o,
    input  logic                  burst_resp_i
);

    localparam int unsigned BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W = $clog2(BEATS);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [LINE_WIDTH-1:0] buf_q;
    logic [31:0]           addr_q;
    logic                  burst_read_q;
    logic                  burst_write_q;
    logic                  resp_q;
    logic                  last_beat;
    logic                  unused_offset;

    assign last_beat     = (cnt_q == CNT_W'(BEATS - 1));
    assign unused_offset = ^line_address_i[OFFSET_BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            buf_q         <= '0;
            addr_q        <= '0;
            burst_read_q  <= 1'b0;
            burst_write_q <= 1'b0;
            resp_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Simultaneous read and write requests are ambiguous and dropped.
                    if (line_read_i ^ line_write_i) begin
                        addr_q <= {line_address_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        cnt_q  <= '0;
                        if (line_write_i) begin
                            buf_q         <= line_wdata_i;
                            burst_write_q <= 1'b1;
                            state_q       <= StWrite;
                        end else begin
                            burst_read_q  <= 1'b1;
                            state_q       <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (burst_resp_i) begin
                        buf_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= burst_rdata_i;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            burst_read_q <= 1'b0;
                            resp_q       <= 1'b1;
                            state_q      <= StDone;
                        end
                    end
                end
                StWrite: begin
                    if (burst_resp_i) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            burst_write_q <= 1'b0;
                            resp_q        <= 1'b1;
                            state_q       <= StDone;
                        end
                    end
                end
                StDone: begin
                    resp_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    burst_read_q  <= 1'b0;
                    burst_write_q <= 1'b0;
                    resp_q        <= 1'b0;
                    state_q       <= StIdle;
                end
            endcase
        end
    end

    // Counter rests at 0 outside a burst, so the write beat defaults to beat 0.
    assign burst_wdata_o   = buf_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH];
    assign burst_address_o = addr_q;
    assign burst_read_o    = burst_read_q;
    assign burst_write_o   = burst_write_q;
    assign line_resp_o     = resp_q;
    assign line_rdata_o    = buf_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomised bench for cacheline_adaptor; the bench plays the burst memory and
// models the expected line buffer and response timing from beat counts.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  line_address_i;
    logic [255:0] line_rdata_o;
    logic [255:0] line_wdata_i;
    logic         line_read_i;
    logic         line_write_i;
    logic         line_resp_o;
    logic [31:0]  burst_address_o;
    logic [63:0]  burst_rdata_i;
    logic [63:0]  burst_wdata_o;
    logic         burst_read_o;
    logic         burst_write_o;
    logic         burst_resp_i;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [255:0] exp_buf;

    cacheline_adaptor dut (
        .clk             (clk),
        .rst             (rst),
        .line_address_i  (line_address_i),
        .line_rdata_o    (line_rdata_o),
        .line_wdata_i    (line_wdata_i),
        .line_read_i     (line_read_i),
        .line_write_i    (line_write_i),
        .line_resp_o     (line_resp_o),
        .burst_address_o (burst_address_o),
        .burst_rdata_i   (burst_rdata_i),
        .burst_wdata_o   (burst_wdata_o),
        .burst_read_o    (burst_read_o),
        .burst_write_o   (burst_write_o),
        .burst_resp_i    (burst_resp_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // One full transaction with the bench acting as memory. pat (if pat_len>0) gives the
    // per-cycle ack pattern, otherwise acks are random with wait_pct percent wait states.
    task automatic run_txn(input string name, input bit wr, input logic [31:0] addr,
                           input logic [255:0] line, input logic [15:0] pat, input int pat_len,
                           input int wait_pct, input bit drop, input bit hold,
                           input int exp_done_cyc);
        logic [31:0] exp_addr;
        int acks, cyc;
        bit ack;
        exp_addr       = {addr[31:5], 5'b0};
        line_address_i = addr;
        line_wdata_i   = wr ? line : rand_line();
        line_read_i    = !wr;
        line_write_i   = wr;
        burst_resp_i   = 1'b0;
        step();
        if (wr) exp_buf = line;
        // Upstream inputs must not be re-sampled once the burst is running.
        line_address_i = $urandom;
        line_wdata_i   = rand_line();
        acks = 0;
        cyc  = 1;
        while (acks < 4 && cyc < 200) begin
            n_cmp++;
            if (burst_read_o !== !wr || burst_write_o !== wr) begin
                n_fail++;
                $display("FAIL %s strobe cyc%0d: rd=%b wr=%b, want rd=%b wr=%b",
                         name, cyc, burst_read_o, burst_write_o, !wr, wr);
            end
            n_cmp++;
            if (line_resp_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s early_resp cyc%0d: got %b want 0", name, cyc, line_resp_o);
            end
            n_cmp++;
            if (burst_address_o !== exp_addr) begin
                n_fail++;
                $display("FAIL %s address cyc%0d: got %h want %h", name, cyc,
                         burst_address_o, exp_addr);
            end
            if (wr) begin
                n_cmp++;
                if (burst_wdata_o !== line[acks*64 +: 64]) begin
                    n_fail++;
                    $display("FAIL %s wdata beat%0d cyc%0d: got %h want %h", name, acks, cyc,
                             burst_wdata_o, line[acks*64 +: 64]);
                end
            end
            n_cmp++;
            if (line_rdata_o !== exp_buf) begin
                n_fail++;
                $display("FAIL %s rdata_mid cyc%0d: got %h want %h", name, cyc,
                         line_rdata_o, exp_buf);
            end
            if (drop && acks >= 1) begin
                line_read_i  = 1'b0;
                line_write_i = 1'b0;
            end
            if (pat_len > 0) ack = (cyc - 1 < pat_len) ? pat[cyc-1] : 1'b1;
            else             ack = ($urandom_range(0, 99) >= wait_pct);
            burst_resp_i  = ack;
            burst_rdata_i = (ack && !wr) ? line[acks*64 +: 64] : {$urandom, $urandom};
            step();
            if (ack) begin
                if (!wr) exp_buf[acks*64 +: 64] = line[acks*64 +: 64];
                acks++;
            end
            cyc++;
        end
        n_cmp++;
        if (acks < 4) begin
            n_fail++;
            $display("FAIL %s burst_timeout: %0d beats taken, want 4", name, acks);
        end
        // Completion cycle.
        if (exp_done_cyc != 0) begin
            n_cmp++;
            if (cyc !== exp_done_cyc) begin
                n_fail++;
                $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, exp_done_cyc);
            end
        end
        n_cmp++;
        if (line_resp_o !== 1'b1 || burst_read_o !== 1'b0 || burst_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done: resp=%b rd=%b wr=%b, want resp=1 rd=0 wr=0", name,
                     line_resp_o, burst_read_o, burst_write_o);
        end
        n_cmp++;
        if (line_rdata_o !== (wr ? line : exp_buf)) begin
            n_fail++;
            $display("FAIL %s line_rdata: got %h want %h", name, line_rdata_o, exp_buf);
        end
        if (!wr) begin
            n_cmp++;
            if (line_rdata_o !== line) begin
                n_fail++;
                $display("FAIL %s read_line: got %h want %h", name, line_rdata_o, line);
            end
        end
        burst_resp_i = 1'($urandom_range(0, 1));
        if (!hold) begin
            line_read_i  = 1'b0;
            line_write_i = 1'b0;
        end
        step();
        n_cmp++;
        if (line_resp_o !== 1'b0 || burst_read_o !== 1'b0 || burst_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_done: resp=%b rd=%b wr=%b, want all 0", name,
                     line_resp_o, burst_read_o, burst_write_o);
        end
        n_cmp++;
        if (line_rdata_o !== exp_buf) begin
            n_fail++;
            $display("FAIL %s rdata_hold: got %h want %h", name, line_rdata_o, exp_buf);
        end
        if (!hold) begin
            burst_resp_i = 1'($urandom_range(0, 1));
            step();
            n_cmp++;
            if (line_resp_o !== 1'b0 || burst_read_o !== 1'b0 || burst_write_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stays_idle: resp=%b rd=%b wr=%b, want all 0", name,
                         line_resp_o, burst_read_o, burst_write_o);
            end
            burst_resp_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #7;
        n_cmp++;
        if (line_resp_o !== 0 || burst_read_o !== 0 || burst_write_o !== 0 ||
            burst_address_o !== 0 || burst_wdata_o !== 0 || line_rdata_o !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, want 0",
                     line_resp_o, burst_read_o, burst_write_o, burst_address_o,
                     burst_wdata_o, line_rdata_o);
        end
        rst = 1'b0;
        exp_buf = '0;
        step();
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] l;
        l = rand_line();
        line_address_i = 32'h0000_8040;
        line_read_i    = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            burst_resp_i  = 1'b1;
            burst_rdata_i = l[i*64 +: 64];
            step();
        end
        burst_resp_i = 1'b0;
        n_cmp++;
        if (burst_read_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_pre: burst_read=%b want 1", burst_read_o);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (line_resp_o !== 0 || burst_read_o !== 0 || burst_write_o !== 0 ||
            burst_address_o !== 0 || burst_wdata_o !== 0 || line_rdata_o !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_async: resp=%b rd=%b wr=%b addr=%h rdata=%h, want 0",
                     line_resp_o, burst_read_o, burst_write_o, burst_address_o, line_rdata_o);
        end
        line_read_i = 1'b0;
        exp_buf = '0;
        #2 rst = 1'b0;
        step();
        n_cmp++;
        if (burst_read_o !== 0 || burst_write_o !== 0 || line_resp_o !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: rd=%b wr=%b resp=%b, want 0",
                     burst_read_o, burst_write_o, line_resp_o);
        end
        run_txn("reset_fresh_read", 1'b0, 32'h0000_8044, rand_line(), 16'hFFFF, 4, 0, 0, 0, 5);
    endtask

    task automatic test_read_zero_wait();
        logic [255:0] l;
        l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        run_txn("read_zero_wait", 1'b0, 32'h0000_1234, l, 16'hFFFF, 4, 0, 0, 0, 5);
    endtask

    task automatic test_write_waits();
        run_txn("write_waits", 1'b1, 32'hDEAD_BEEF, rand_line(), 16'h0065, 7, 0, 0, 0, 8);
    endtask

    task automatic test_both_requests();
        logic [31:0] prev_addr;
        prev_addr      = burst_address_o;
        line_address_i = 32'h1234_5678;
        line_wdata_i   = rand_line();
        line_read_i    = 1'b1;
        line_write_i   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            burst_resp_i = 1'($urandom_range(0, 1));
            step();
            n_cmp++;
            if (burst_read_o !== 0 || burst_write_o !== 0 || line_resp_o !== 0 ||
                burst_address_o !== prev_addr || line_rdata_o !== exp_buf) begin
                n_fail++;
                $display("FAIL both_req cyc%0d: rd=%b wr=%b resp=%b addr=%h, want 0 0 0 %h",
                         i, burst_read_o, burst_write_o, line_resp_o, burst_address_o, prev_addr);
            end
        end
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        burst_resp_i = 1'b0;
        step();
    endtask

    task automatic test_drop_request();
        run_txn("drop_req", 1'b0, $urandom, rand_line(), 16'h0, 0, 30, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        a = $urandom;
        run_txn("b2b_write", 1'b1, $urandom, rand_line(), 16'hFFFF, 4, 0, 0, 1, 5);
        run_txn("b2b_read", 1'b0, a, rand_line(), 16'h0, 0, 25, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            run_txn("random", 1'($urandom_range(0, 1)), $urandom, rand_line(), 16'h0, 0,
                    $urandom_range(0, 60), 1'($urandom_range(0, 1)), 0, 0);
        end
    endtask

    initial begin
        line_address_i = '0;
        line_wdata_i   = '0;
        line_read_i    = 1'b0;
        line_write_i   = 1'b0;
        burst_rdata_i  = '0;
        burst_resp_i   = 1'b0;
        exp_buf        = '0;
        test_reset();
        test_reset_mid_burst();
        test_read_zero_wait();
        test_write_waits();
        test_both_requests();
        test_drop_request();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
